// File: rtl/tdc_arb_pkg.sv
// Shared definitions for the TDC hit path: default sizing, channel-index width
// helper and the hit-word type used by the channel FIFOs and the packer.
package tdc_arb_pkg;

  localparam int DEFAULT_N_CH   = 24;
  localparam int DEFAULT_DATA_W = 32;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [DEFAULT_DATA_W-1:0] hit_word_t;

endpackage

// File: rtl/tdc_hit_arbiter_rr_pick.sv
// Round-robin pick: rotating mask in front of two lowest-index-first encoders,
// falling back to the unmasked request when nothing lies above the pointer.
module prio_enc
  import tdc_arb_pkg::*;
#(
  parameter int N     = DEFAULT_N_CH,
  parameter int IDX_W = ch_width(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign onehot = req & (~req + N'(1));
  assign any    = |req;

endmodule

module rr_pick
  import tdc_arb_pkg::*;
#(
  parameter int N_CH = DEFAULT_N_CH,
  parameter int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            any
);

  logic [N_CH-1:0] mask;
  logic [N_CH-1:0] mreq;
  logic [N_CH-1:0] m_onehot;
  logic [N_CH-1:0] r_onehot;
  logic [CH_W-1:0] m_idx;
  logic [CH_W-1:0] r_idx;
  logic            m_any;
  logic            r_any;

  // Only channels strictly above the last winner get first chance.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      mask[i] = (CH_W'(i) > ptr);
    end
  end

  assign mreq = req & mask;

  prio_enc #(.N(N_CH), .IDX_W(CH_W)) u_masked (
    .req    (mreq),
    .onehot (m_onehot),
    .idx    (m_idx),
    .any    (m_any)
  );

  prio_enc #(.N(N_CH), .IDX_W(CH_W)) u_unmasked (
    .req    (req),
    .onehot (r_onehot),
    .idx    (r_idx),
    .any    (r_any)
  );

  assign grant     = m_any ? m_onehot : r_onehot;
  assign grant_idx = m_any ? m_idx    : r_idx;
  assign any       = r_any;

endmodule

// File: rtl/tdc_hit_arbiter.sv
// Merges hit words from the per-channel TDC FIFOs into one registered stream
// using round-robin arbitration; keeps a saturating count of grants.
module tdc_hit_arbiter
  import tdc_arb_pkg::*;
#(
  parameter int   N_CH   = DEFAULT_N_CH,
  parameter int   DATA_W = DEFAULT_DATA_W,
  parameter int   CNT_W  = 16,
  localparam int  CH_W   = ch_width(N_CH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  output logic [N_CH-1:0]        ch_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]        out_ch,
  input  logic                   out_ready,
  input  logic                   cnt_clear,
  output logic [CNT_W-1:0]       grant_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CH_W-1:0]  PTR_INIT = CH_W'(N_CH - 1);

  logic              slot_free;
  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;
  logic [CH_W-1:0]   ptr;
  logic [DATA_W-1:0] sel_data;

  // A new grant may land in the same cycle the held word is popped.
  assign slot_free = !out_valid || out_ready;
  assign req       = (enable && slot_free && reset_n) ? ch_valid : '0;

  rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign ch_ready = grant;

  // AND-OR mux on the one-hot grant keeps the data path free of a wide shifter.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) sel_data = sel_data | ch_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= PTR_INIT;
    end else if (grant_any) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= grant_idx;
      ptr       <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over a simultaneous grant; the count sticks at all-ones.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grant_count <= '0;
    end else if (cnt_clear) begin
      grant_count <= '0;
    end else if (grant_any && (grant_count != CNT_MAX)) begin
      grant_count <= grant_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tdc_hit_arbiter.sv
// Directed bench for tdc_hit_arbiter: stimulus queues the expected output words,
// a negedge monitor pops and compares them as the DUT hands words downstream.
module tb_tdc_hit_arbiter;
  import tdc_arb_pkg::*;

  localparam int N_CH   = 24;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 5;

  logic                   clock;
  logic                   reset_n;
  logic                   enable;
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_ready;
  logic                   cnt_clear;
  logic [CNT_W-1:0]       grant_count;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  tdc_hit_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .ch_ready    (ch_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_ready   (out_ready),
    .cnt_clear   (cnt_clear),
    .grant_count (grant_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic hit_word_t hit_of(input int ch);
    return 32'hA5A5_0001 + 32'(ch);
  endfunction

  function automatic logic [N_CH-1:0] bit_of(input int k);
    logic [N_CH-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expectWord(input int ch);
    exp_t e;
    e.ch   = CH_W'(ch);
    e.data = hit_of(ch);
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] valid, input logic ready,
                               input logic en);
    ch_valid  = valid;
    out_ready = ready;
    enable    = en;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted output word must match the head of the queue.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_unexpected: got ch %0d data 0x%0h, expected no word at %0t",
                 out_ch, out_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_ch", 64'(out_ch), 64'(mon_e.ch));
        checkOutput("sb_data", 64'(out_data), 64'(mon_e.data));
      end
    end
    if (ch_ready != '0)
      checkOutput("ready_legal",
                  64'($onehot(ch_ready) && ((ch_ready & ~ch_valid) == '0)), 64'd1);
  end

  initial begin
    reset_n   = 1'b0;
    cnt_clear = 1'b0;
    for (int i = 0; i < N_CH; i++) ch_data[i*DATA_W +: DATA_W] = hit_of(i);
    applyStimulus('1, 1'b1, 1'b1);
    tick(2);
    checkOutput("reset_ready", 64'(ch_ready), 64'd0);
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_data", 64'(out_data), 64'd0);
    checkOutput("reset_ch", 64'(out_ch), 64'd0);
    checkOutput("reset_count", 64'(grant_count), 64'd0);

    reset_n = 1'b1;
    applyStimulus('0, 1'b1, 1'b1);
    tick(2);
    checkOutput("idle_valid", 64'(out_valid), 64'd0);
    checkOutput("idle_ready", 64'(ch_ready), 64'd0);

    // Single word from channel 0
    applyStimulus(bit_of(0), 1'b1, 1'b1);
    expectWord(0);
    #1;
    checkOutput("t1_ready", 64'(ch_ready), 64'(bit_of(0)));
    tick(1);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t1_valid", 64'(out_valid), 64'd1);
    checkOutput("t1_ch", 64'(out_ch), 64'd0);
    checkOutput("t1_data", 64'(out_data), 64'hA5A5_0001);
    checkOutput("t1_count", 64'(grant_count), 64'd1);
    #1;
    checkOutput("t1_ready_once", 64'(ch_ready), 64'd0);
    tick(1);
    checkOutput("t1_drain", 64'(out_valid), 64'd0);

    // All channels requesting: 0..23 twice, no bubbles
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    applyStimulus('1, 1'b1, 1'b1);
    for (int k = 0; k < 48; k++) expectWord(k % N_CH);
    for (int k = 0; k < 48; k++) begin
      tick(1);
      checkOutput("t2_no_bubble", 64'(out_valid), 64'd1);
    end
    checkOutput("t2_count", 64'(grant_count), 64'd48);
    applyStimulus('0, 1'b1, 1'b1);
    tick(1);
    checkOutput("t2_drain", 64'(out_valid), 64'd0);

    // Channels 3 and 20 with pointer parked at 20
    applyStimulus(bit_of(20), 1'b1, 1'b1);
    expectWord(20);
    tick(1);
    applyStimulus(bit_of(3) | bit_of(20), 1'b1, 1'b1);
    #1;
    checkOutput("t3_wrap_to_3", 64'(ch_ready), 64'(bit_of(3)));
    expectWord(3);
    tick(1);
    checkOutput("t3_then_20", 64'(ch_ready), 64'(bit_of(20)));
    expectWord(20);
    tick(1);
    checkOutput("t3_wrap_again", 64'(ch_ready), 64'(bit_of(3)));
    expectWord(3);
    tick(1);
    applyStimulus('0, 1'b1, 1'b1);
    tick(1);
    checkOutput("t3_drain", 64'(out_valid), 64'd0);

    // Backpressure: channel 7 held, channel 9 waiting
    applyStimulus(bit_of(7), 1'b1, 1'b1);
    expectWord(7);
    tick(1);
    applyStimulus(bit_of(9), 1'b0, 1'b1);
    #1;
    checkOutput("t4_blocked", 64'(ch_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      checkOutput("t4_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("t4_hold_ch", 64'(out_ch), 64'd7);
      checkOutput("t4_hold_data", 64'(out_data), 64'(hit_of(7)));
      checkOutput("t4_hold_ready", 64'(ch_ready), 64'd0);
    end
    applyStimulus(bit_of(9), 1'b1, 1'b1);
    #1;
    checkOutput("t4_same_cycle", 64'(ch_ready), 64'(bit_of(9)));
    expectWord(9);
    tick(1);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t4_next_ch", 64'(out_ch), 64'd9);
    tick(1);

    // enable dropped while a word is held
    applyStimulus(bit_of(12), 1'b0, 1'b1);
    expectWord(12);
    tick(1);
    applyStimulus(bit_of(1) | bit_of(2), 1'b0, 1'b0);
    tick(2);
    checkOutput("t5_held_valid", 64'(out_valid), 64'd1);
    checkOutput("t5_held_ch", 64'(out_ch), 64'd12);
    applyStimulus(bit_of(1) | bit_of(2), 1'b1, 1'b0);
    #1;
    checkOutput("t5_no_grant", 64'(ch_ready), 64'd0);
    tick(1);
    checkOutput("t5_drained", 64'(out_valid), 64'd0);
    checkOutput("t5_still_none", 64'(ch_ready), 64'd0);
    tick(3);
    checkOutput("t5_idle_valid", 64'(out_valid), 64'd0);
    applyStimulus(bit_of(1) | bit_of(2), 1'b1, 1'b1);
    #1;
    checkOutput("t5_resume_1", 64'(ch_ready), 64'(bit_of(1)));
    expectWord(1);
    tick(1);
    applyStimulus(bit_of(2), 1'b1, 1'b1);
    #1;
    checkOutput("t5_resume_2", 64'(ch_ready), 64'(bit_of(2)));
    expectWord(2);
    tick(1);
    applyStimulus('0, 1'b1, 1'b1);
    tick(1);

    // Grant counter: 48 + 4 + 2 + 3 grants since the last reset
    checkOutput("cnt_total", 64'(grant_count), 64'd57);
    cnt_clear = 1'b1;
    tick(1);
    cnt_clear = 1'b0;
    checkOutput("cnt_clear_idle", 64'(grant_count), 64'd0);
    applyStimulus('1, 1'b1, 1'b1);
    for (int k = 0; k <= 65538; k++) expectWord((3 + k) % N_CH);
    tick(65538);
    checkOutput("cnt_saturate", 64'(grant_count), 64'hFFFF);
    cnt_clear = 1'b1;
    tick(1);
    cnt_clear = 1'b0;
    checkOutput("cnt_clear_wins", 64'(grant_count), 64'd0);
    checkOutput("cnt_clear_valid", 64'(out_valid), 64'd1);

    // Reset mid-stream discards the held word and re-parks the pointer
    applyStimulus('1, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_ready", 64'(ch_ready), 64'd0);
    checkOutput("rst_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    tick(1);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_ch", 64'(out_ch), 64'd0);
    reset_n = 1'b1;
    applyStimulus(bit_of(5) | bit_of(17), 1'b1, 1'b1);
    #1;
    checkOutput("rst_first_grant", 64'(ch_ready), 64'(bit_of(5)));
    expectWord(5);
    tick(1);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("rst_out_ch", 64'(out_ch), 64'd5);
    checkOutput("rst_count", 64'(grant_count), 64'd1);
    tick(2);
    checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_hit_arbiter.md
Name: tdc_hit_arbiter

Overview:
Round-robin arbiter that merges hit words from N_CH TDC channel buffers into one registered output stream. Each cycle the output slot can accept, it grants at most one requesting channel. Fairness comes from a rotating mask in front of a lowest-index-first priority encoder. The block sits between the per-channel TDC hit FIFOs and the shared hit serializer/packer.

Parameters:
N_CH, 24, number of requesting channels (one per TDC channel); must be >= 2
DATA_W, 32, hit word width
CNT_W, 16, width of saturating grant counter
CH_W, $clog2(N_CH), channel-index width; derived, not overridable

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  synchronous active-low reset
enable  in  1  1 = arbitration allowed; 0 = no new grants, output still drains
ch_valid  in  N_CH  per-channel word-available
ch_data  in  N_CH*DATA_W  per-channel hit words; channel i occupies [i*DATA_W +: DATA_W]
ch_ready  out  N_CH  one-hot grant/pop strobe, combinational
out_valid  out  1  output word valid (registered)
out_data  out  DATA_W  granted hit word (registered)
out_ch  out  CH_W  index of the channel that produced out_data (registered)
out_ready  in  1  downstream accept
cnt_clear  in  1  synchronous clear of grant_count
grant_count  out  CNT_W  total grants, saturating

Behaviour:
- Reset (reset_n=0 at a clock edge): out_valid=0, out_data=0, out_ch=0, grant_count=0, last-grant pointer=N_CH-1 (so channel 0 wins first). ch_ready=0 while reset_n=0. Reset mid-transfer discards the registered word.
- Slot free: slot_free = !out_valid | out_ready.
- Request vector: req = ch_valid when enable & slot_free & reset_n, else 0.
- Rotating mask: mask = bits with index > ptr.
- Masked request: mreq = req & mask.
- Grant selection: if |mreq, grant the lowest set index of mreq; otherwise grant the lowest set index of req.
- ch_ready: one-hot of the granted index, all zero if req==0. Exactly one bit is set per accept. A channel transfers on the cycle where ch_valid[i]&ch_ready[i].
- On a grant at edge k:
  - out_valid=1 at k+1.
  - out_data=ch_data slice of the granted channel.
  - out_ch=granted index.
  - ptr=granted index.
  - Latency: 1 cycle from grant to out_valid.
- No grant with out_ready=1: out_valid clears at the next edge.
- No grant with out_ready=0: out_valid, out_data and out_ch hold unchanged.
- Full throughput: a new grant is allowed in the same cycle out_ready pops the current word, giving back-to-back words with no bubbles.
- ptr changes only on a grant. Idle cycles do not rotate priority.
- Wrap-around: after granting N_CH-1 the mask is empty, so the lowest requester wins.
- Fairness: with all N_CH channels continuously requesting and out_ready=1, grants cycle 0,1,...,N_CH-1,0,...; every channel is served within N_CH grants.
- enable dropped while out_valid=1: the held word is still delivered. No further grants until enable=1.
- grant_count: increments by 1 per grant and saturates at 2**CNT_W-1. cnt_clear=1 sets it to 0 and takes precedence over a simultaneous grant.
- ch_valid must stay high until granted. The arbiter never grants a channel whose ch_valid=0.

Decomposition:
- Shared package tdc_arb_pkg holds:
  - default N_CH and DATA_W constants;
  - CH_W derivation function;
  - the hit-word typedef (DATA_W bits), used by the FIFOs and the packer.
- Sub-module rr_pick (combinational): inputs req and ptr; outputs grant one-hot, grant index and any. Internally it uses two instances of the team's parameterized priority encoder (masked and unmasked, lowest index wins) plus the select mux.
- Top level holds the output register, ptr, counter and handshake.

Test Plan:
- Reset then idle, out_ready=1: out_valid=0, ch_ready=0, grant_count=0. Then ch_valid=24'h000001, ch_data[0]=32'hA5A5_0001 → ch_ready=24'h000001 for 1 cycle; next cycle out_valid=1, out_data=32'hA5A5_0001, out_ch=0, grant_count=1.
- All channels valid, out_ready=1, 48 cycles → out_ch sequence 0..23,0..23 with no bubbles; grant_count=48.
- ch_valid bits 3 and 20 held, ptr=20 → next grant 3, then 20, then 3 (wrap); ch_ready never set for an unrequested bit.
- Backpressure: out_ready=0 for 5 cycles with word from ch 7 registered, ch 9 requesting → out_data/out_ch stable, ch_ready=0; out_ready=1 → ch 7 word popped and ch 9 granted in the same cycle.
- enable=0 with out_valid=1 and requests pending → held word delivered on out_ready, then out_valid=0 and no ch_ready until enable=1.
- Counter: preload via 65 535 grants plus 3 more → grant_count=16'hFFFF; assert cnt_clear together with a grant → grant_count=0; reset_n=0 mid-stream → out_valid=0 next edge, ptr=23, first grant after reset goes to the lowest requester.
